// File: rtl/prog_loader_if.sv
// prog_loader_if -- byte stream into the programming-chain loader.
//   data_in    : config byte, MSB is shifted into the chain first
//   data_valid : source has a byte on data_in
//   data_ready : loader takes data_in on this edge when data_valid is also high
// master = byte source, slave = prog_loader.
interface prog_loader_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- streams config bytes serially into a CHAIN_LEN-bit programming
// chain while capturing the old chain contents for readback.
//   prog_clk   : clock, all state changes on its rising edge
//   prog_rst   : asynchronous active-high reset
//   start      : begin a load (only looked at in IDLE)
//   abort      : cancel an active load
//   dbus       : byte stream (data_in / data_valid / data_ready)
//   prog_en    : chain shift enable
//   prog_in    : chain serial data
//   chain_out  : serial output of the last chain stage
//   rb_data    : readback byte, first captured bit in bit 7
//   rb_valid   : one-cycle strobe for rb_data
//   busy       : high while loading
//   done       : one-cycle pulse when a load completes normally
module prog_loader #(
    parameter int unsigned CHAIN_LEN = 16
) (
    input  logic               prog_clk,
    input  logic               prog_rst,
    input  logic               start,
    input  logic               abort,
    prog_loader_if.slave       dbus,
    output logic               prog_en,
    output logic               prog_in,
    input  logic               chain_out,
    output logic [7:0]         rb_data,
    output logic               rb_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NB     = (CHAIN_LEN + 7) / 8;
    localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BYTE_W = $clog2(NB + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BYTE_W-1:0] NB_L     = BYTE_W'(NB);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [7:0]        shift_buf;
    logic [3:0]        buf_bits;
    logic [7:0]        rb_sr;
    logic [3:0]        rb_cnt;

    logic       in_load;
    logic       accept;
    logic       final_shift;
    logic [7:0] rb_next;
    logic [3:0] rb_cnt_next;
    logic [7:0] rb_aligned;

    assign in_load         = (state == LOAD);
    // Ready already at one buffered bit so the next byte lands on the edge that
    // shifts that bit out, keeping the chain shifting without gaps.
    assign dbus.data_ready = in_load && (buf_bits <= 4'd1) && (byte_cnt < NB_L);
    assign prog_en         = in_load && (buf_bits != 4'd0);
    assign prog_in         = shift_buf[7];

    always_comb begin
        accept      = dbus.data_valid && dbus.data_ready;
        final_shift = prog_en && (bit_cnt == LAST_BIT);
        rb_next     = {rb_sr[6:0], chain_out};
        rb_cnt_next = rb_cnt + 4'd1;
        // A short final byte is left-aligned; stale high bits shift out.
        rb_aligned  = rb_next << (4'd8 - rb_cnt_next);
    end

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_buf <= '0;
            buf_bits  <= '0;
            rb_sr     <= '0;
            rb_cnt    <= '0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        shift_buf <= '0;
                        buf_bits  <= '0;
                        rb_sr     <= '0;
                        rb_cnt    <= '0;
                    end
                end
                LOAD: begin
                    // Capture happens on every shift edge, including an
                    // aborted one, since the chain itself still shifts.
                    if (prog_en) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        rb_sr   <= rb_next;
                        if (rb_cnt_next == 4'd8 || final_shift) begin
                            rb_cnt <= '0;
                            if (!abort) begin
                                rb_valid <= 1'b1;
                                rb_data  <= rb_aligned;
                            end
                        end else begin
                            rb_cnt <= rb_cnt_next;
                        end
                    end
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        shift_buf <= '0;
                        buf_bits  <= '0;
                    end else if (final_shift) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        shift_buf <= '0;
                        buf_bits  <= '0;
                    end else if (accept) begin
                        shift_buf <= dbus.data_in;
                        buf_bits  <= 4'd8;
                        byte_cnt  <= byte_cnt + 1'b1;
                    end else if (prog_en) begin
                        shift_buf <= {shift_buf[6:0], 1'b0};
                        buf_bits  <= buf_bits - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed, table-driven bench for prog_loader.
// Two instances (CHAIN_LEN 16 and 12) each drive a behavioural chain model;
// sel picks which instance a load runs against.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    logic [1:0] dv_v    = '0;
    logic [7:0] din     = '0;
    logic       sel     = 1'b0;

    prog_loader_if if16 ();
    prog_loader_if if12 ();
    assign if16.data_in    = din;
    assign if16.data_valid = dv_v[0];
    assign if12.data_in    = din;
    assign if12.data_valid = dv_v[1];

    logic       en16, pin16, rbv16, busy16, done16, co16;
    logic       en12, pin12, rbv12, busy12, done12, co12;
    logic [7:0] rbd16, rbd12;

    // Chain models: prog_in enters bit 0, chain_out is the MSB.
    logic [15:0] chain16;
    logic [11:0] chain12;
    logic        pre16 = 1'b0, pre12 = 1'b0;
    logic [15:0] pre_val16 = '0;
    logic [11:0] pre_val12 = '0;

    always @(posedge clk) begin
        if (pre16)     chain16 <= pre_val16;
        else if (en16) chain16 <= {chain16[14:0], pin16};
        if (pre12)     chain12 <= pre_val12;
        else if (en12) chain12 <= {chain12[10:0], pin12};
    end
    assign co16 = chain16[15];
    assign co12 = chain12[11];

    prog_loader #(.CHAIN_LEN(16)) dut16 (
        .prog_clk(clk), .prog_rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .dbus(if16), .prog_en(en16), .prog_in(pin16), .chain_out(co16),
        .rb_data(rbd16), .rb_valid(rbv16), .busy(busy16), .done(done16)
    );

    prog_loader #(.CHAIN_LEN(12)) dut12 (
        .prog_clk(clk), .prog_rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .dbus(if12), .prog_en(en12), .prog_in(pin12), .chain_out(co12),
        .rb_data(rbd12), .rb_valid(rbv12), .busy(busy12), .done(done12)
    );

    logic       o_rdy, o_en, o_pin, o_rbv, o_busy, o_done;
    logic [7:0] o_rbd;
    assign o_rdy  = sel ? if12.data_ready : if16.data_ready;
    assign o_en   = sel ? en12   : en16;
    assign o_pin  = sel ? pin12  : pin16;
    assign o_rbv  = sel ? rbv12  : rbv16;
    assign o_rbd  = sel ? rbd12  : rbd16;
    assign o_busy = sel ? busy12 : busy16;
    assign o_done = sel ? done12 : done16;

    typedef struct {
        logic        sel;
        logic        hold_start;
        logic        pre;
        logic [11:0] pre_val;
        logic [7:0]  b0, b1, b2;
        int unsigned stall;
        int unsigned abort_after;
        logic [15:0] exp_bits;
        int unsigned exp_n, exp_gaps, exp_done, exp_acc, exp_nrb;
        logic [7:0]  exp_rb0, exp_rb1;
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        int unsigned n, gaps, dn, acc, nrb;
        logic [7:0]  rb0, rb1;
        logic        busy_at_done;
        logic        late_act;
        logic        timeout;
    } res_t;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic hs, input logic pre,
                                input logic [11:0] pv, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input int unsigned stall, input int unsigned ab,
                                input logic [15:0] eb, input int unsigned en,
                                input int unsigned eg, input int unsigned ed,
                                input int unsigned ea, input int unsigned enrb,
                                input logic [7:0] r0, input logic [7:0] r1);
        vec_t v;
        v.sel = s; v.hold_start = hs; v.pre = pre; v.pre_val = pv;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.stall = stall; v.abort_after = ab;
        v.exp_bits = eb; v.exp_n = en; v.exp_gaps = eg; v.exp_done = ed;
        v.exp_acc = ea; v.exp_nrb = enrb; v.exp_rb0 = r0; v.exp_rb1 = r1;
        return v;
    endfunction

    // Runs one load; inputs change and outputs are sampled on the falling edge.
    task automatic run_load(input vec_t v, output res_t r);
        logic [7:0]  bytes [3];
        int unsigned bidx, stall_left, pend, tail;
        logic        fin;
        bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
        r.bits = '0; r.n = 0; r.gaps = 0; r.dn = 0; r.acc = 0; r.nrb = 0;
        r.rb0 = '0; r.rb1 = '0; r.busy_at_done = 1'b0; r.late_act = 1'b0;
        r.timeout = 1'b1;
        sel = v.sel;
        if (v.pre) begin
            // Stage order of this chain makes the low byte emerge first.
            @(negedge clk);
            pre_val12 = {v.pre_val[7:0], v.pre_val[11:8]};
            pre12 = 1'b1;
            @(negedge clk);
            pre12 = 1'b0;
        end
        @(negedge clk);
        start_v[v.sel] = 1'b1;
        bidx = 0; stall_left = v.stall; pend = 0; tail = 0; fin = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            abort_v = '0;
            if (!v.hold_start) start_v = '0;
            if (fin) begin
                tail++;
                if (o_busy || o_en) r.late_act = 1'b1;
                if (o_done) r.dn++;
                if (tail == 3) begin
                    r.timeout = 1'b0;
                    break;
                end
                continue;
            end
            if (o_done) begin
                r.dn++;
                r.busy_at_done = o_busy;
                start_v = '0;
                fin = 1'b1;
            end
            if (o_rbv) begin
                if (r.nrb == 0) r.rb0 = o_rbd;
                else if (r.nrb == 1) r.rb1 = o_rbd;
                r.nrb++;
            end
            if (o_en) begin
                r.bits = {r.bits[14:0], o_pin};
                r.n++;
                r.gaps += pend;
                pend = 0;
            end else if (r.n > 0) begin
                pend++;
            end
            if (v.abort_after != 0 && o_en && r.n == v.abort_after) begin
                abort_v[v.sel] = 1'b1;
                fin = 1'b1;
            end
            if (bidx == 1 && stall_left > 0 && o_rdy) begin
                dv_v = '0;
                stall_left--;
            end else begin
                dv_v[v.sel] = (bidx < 3);
            end
            din = (bidx < 3) ? bytes[bidx] : 8'h00;
            if (o_rdy && dv_v[v.sel]) begin
                r.acc++;
                bidx++;
            end
        end
        start_v = '0;
        abort_v = '0;
        dv_v    = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs [7];
    res_t r;
    vec_t hv;

    initial begin
        // sel hs pre pre_val b0 b1 b2 stall abort | bits n gaps done acc nrb rb0 rb1
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 12'h000, 8'hA5, 8'h3C, 8'h11, 0, 0,  16'hA53C, 16, 0, 1, 2, 2, 8'h00, 8'h00);
        vecs[1] = mk(1'b0, 1'b1, 1'b0, 12'h000, 8'h0F, 8'hF0, 8'h22, 0, 0,  16'h0FF0, 16, 0, 1, 2, 2, 8'hA5, 8'h3C);
        vecs[2] = mk(1'b1, 1'b0, 1'b1, 12'h5A5, 8'hFF, 8'h0F, 8'h77, 0, 0,  16'h0FF0, 12, 0, 1, 2, 2, 8'hA5, 8'h50);
        vecs[3] = mk(1'b1, 1'b0, 1'b0, 12'h000, 8'h96, 8'hC3, 8'h77, 5, 0,  16'h096C, 12, 5, 1, 2, 2, 8'hFF, 8'h00);
        vecs[4] = mk(1'b1, 1'b0, 1'b0, 12'h000, 8'h12, 8'h34, 8'h77, 0, 5,  16'h0002,  5, 0, 0, 1, 0, 8'h00, 8'h00);
        vecs[5] = mk(1'b1, 1'b0, 1'b0, 12'h000, 8'h5A, 8'hC3, 8'h77, 0, 0,  16'h05AC, 12, 0, 1, 2, 2, 8'hD8, 8'h20);
        vecs[6] = mk(1'b1, 1'b0, 1'b0, 12'h000, 8'h3C, 8'h81, 8'h77, 0, 12, 16'h03C8, 12, 0, 0, 2, 1, 8'h5A, 8'h00);

        // Reset state, both instances.
        pre16 = 1'b1; pre12 = 1'b1; pre_val16 = '0; pre_val12 = '0;
        repeat (2) @(negedge clk);
        pre16 = 1'b0; pre12 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset_outputs.sel%0d", s),
                {17'd0, o_rdy, o_en, o_pin, o_rbv, o_rbd, o_busy, o_done}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i], r);
            chk($sformatf("v%0d.timeout", i), {31'd0, r.timeout}, 32'd0);
            chk($sformatf("v%0d.bits", i), {16'd0, r.bits}, {16'd0, vecs[i].exp_bits});
            chk($sformatf("v%0d.shifts", i), r.n, vecs[i].exp_n);
            chk($sformatf("v%0d.gaps", i), r.gaps, vecs[i].exp_gaps);
            chk($sformatf("v%0d.done", i), r.dn, vecs[i].exp_done);
            chk($sformatf("v%0d.accepted", i), r.acc, vecs[i].exp_acc);
            chk($sformatf("v%0d.rb_count", i), r.nrb, vecs[i].exp_nrb);
            if (vecs[i].exp_nrb >= 1)
                chk($sformatf("v%0d.rb0", i), {24'd0, r.rb0}, {24'd0, vecs[i].exp_rb0});
            if (vecs[i].exp_nrb >= 2)
                chk($sformatf("v%0d.rb1", i), {24'd0, r.rb1}, {24'd0, vecs[i].exp_rb1});
            if (vecs[i].exp_done != 0)
                chk($sformatf("v%0d.busy_at_done", i), {31'd0, r.busy_at_done}, 32'd0);
            chk($sformatf("v%0d.idle_after", i), {31'd0, r.late_act}, 32'd0);
        end

        // abort outside LOAD is ignored: start and abort together from IDLE.
        sel = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b1; abort_v[1] = 1'b1;
        @(negedge clk);
        start_v = '0;
        chk("idle_abort.busy", {31'd0, o_busy}, 32'd1);
        @(negedge clk);
        abort_v = '0;
        chk("load_abort.busy", {31'd0, o_busy}, 32'd0);

        // Reset asserted between edges in the middle of a load.
        sel = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0; din = 8'hA5; dv_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_load.busy", {31'd0, o_busy}, 32'd1);
        chk("mid_load.prog_en", {31'd0, o_en}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset.outputs",
            {17'd0, o_rdy, o_en, o_pin, o_rbv, o_rbd, o_busy, o_done}, 32'd0);
        dv_v = '0; start_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_in_reset.busy", {31'd0, o_busy}, 32'd0);
        start_v = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset.busy", {31'd0, o_busy}, 32'd0);

        // Chain held 0x0FF0 and took four bits 1010 before the reset.
        hv = mk(1'b0, 1'b0, 1'b0, 12'h000, 8'hC3, 8'h5A, 8'h11, 0, 0, 16'hC35A, 16, 0, 1, 2, 2, 8'hFF, 8'h0A);
        run_load(hv, r);
        chk("post_reset.timeout", {31'd0, r.timeout}, 32'd0);
        chk("post_reset.bits", {16'd0, r.bits}, {16'd0, hv.exp_bits});
        chk("post_reset.shifts", r.n, hv.exp_n);
        chk("post_reset.done", r.dn, hv.exp_done);
        chk("post_reset.rb0", {24'd0, r.rb0}, {24'd0, hv.exp_rb0});
        chk("post_reset.rb1", {24'd0, r.rb1}, {24'd0, hv.exp_rb1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
